// File: rtl/store_queue_pkg.sv
// Shared definitions for the store path.
// Store-select encodings and a helper that maps a select code to an access
// size in bytes. A size of 0 marks an undefined select code.
package store_queue_pkg;

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;
    localparam logic [2:0] STORE_SD = 3'b011;

    function automatic logic [3:0] store_bytes(input logic [2:0] sel);
        case (sel)
            STORE_SB: store_bytes = 4'd1;
            STORE_SH: store_bytes = 4'd2;
            STORE_SW: store_bytes = 4'd4;
            STORE_SD: store_bytes = 4'd8;
            default:  store_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_queue_lane_align.sv
// store_lane_align: combinational byte-lane alignment for one store.
// Ports:
//   storesel  store size select
//   addr_lo   byte offset within the bus word (addr mod XLEN/8)
//   data      raw store data, value in the low bits
//   aligned   data moved onto its byte lanes, unenabled lanes zero
//   be        byte enables
//   fault     misaligned, wider than the bus, or undefined select
module store_lane_align
    import store_queue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                   storesel,
    input  logic [$clog2(XLEN/8)-1:0]    addr_lo,
    input  logic [XLEN-1:0]              data,
    output logic [XLEN-1:0]              aligned,
    output logic [XLEN/8-1:0]            be,
    output logic                         fault
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [3:0]           nbytes;
    logic [NB:0]          span;
    logic [NB-1:0][7:0]   din;
    logic [NB-1:0][7:0]   dout;

    assign nbytes = store_bytes(storesel);
    assign din    = data;

    always_comb begin
        // One extra bit so a full-width store does not overflow the shift.
        span  = ((NB+1)'(1) << nbytes) - (NB+1)'(1);
        be    = span[NB-1:0] << addr_lo;
        fault = (nbytes == 4'd0)
             || ({28'd0, nbytes} > 32'(NB))
             || ((addr_lo & OFFW'(nbytes - 4'd1)) != '0);
    end

    // An enabled lane j always holds source byte j-off, which is below the
    // access size, so masking the raw data falls out of the enable gate.
    for (genvar j = 0; j < NB; j++) begin : g_lane
        logic [OFFW-1:0] src;
        assign src     = OFFW'(j) - addr_lo;
        assign dout[j] = be[j] ? din[src] : 8'h00;
    end

    assign aligned = dout;

endmodule

// File: rtl/store_queue.sv
// store_queue: buffers aligned stores and drains them to the memory bus.
// Ports:
//   I_clk, I_rst_n           clock, asynchronous active-low reset
//   I_valid / O_ready        store request handshake from execute
//   I_storesel/I_addr/I_data store size, byte address, raw data
//   O_fault                  one-cycle pulse: last offered store was dropped
//   O_mem_valid/I_mem_ready  head-entry handshake to memory
//   O_mem_addr/data/be       head entry, word-aligned address
//   O_count, O_empty         occupancy
module store_queue
    import store_queue_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 32
) (
    input  logic                      I_clk,
    input  logic                      I_rst_n,
    input  logic                      I_valid,
    output logic                      O_ready,
    input  logic [2:0]                I_storesel,
    input  logic [AWIDTH-1:0]         I_addr,
    input  logic [XLEN-1:0]           I_data,
    output logic                      O_fault,
    output logic                      O_mem_valid,
    input  logic                      I_mem_ready,
    output logic [AWIDTH-1:0]         O_mem_addr,
    output logic [XLEN-1:0]           O_mem_data,
    output logic [XLEN/8-1:0]         O_mem_be,
    output logic [$clog2(DEPTH):0]    O_count,
    output logic                      O_empty
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    logic [AWIDTH-1:0] q_addr [DEPTH];
    logic [XLEN-1:0]   q_data [DEPTH];
    logic [NB-1:0]     q_be   [DEPTH];

    logic [PW-1:0]     wptr, rptr;
    logic [CW-1:0]     count;
    logic              fault_q;

    logic [XLEN-1:0]   al_data;
    logic [NB-1:0]     al_be;
    logic              al_fault;
    logic              offer, enq, deq;

    store_lane_align #(.XLEN(XLEN)) u_align (
        .storesel (I_storesel),
        .addr_lo  (I_addr[OFFW-1:0]),
        .data     (I_data),
        .aligned  (al_data),
        .be       (al_be),
        .fault    (al_fault)
    );

    assign O_ready = (count != CW'(DEPTH));
    assign offer   = I_valid && O_ready;
    assign enq     = offer && !al_fault;
    assign deq     = O_mem_valid && I_mem_ready;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_be[i]   <= '0;
            end
        end else begin
            fault_q <= offer && al_fault;
            if (enq) begin
                q_addr[wptr] <= {I_addr[AWIDTH-1:OFFW], {OFFW{1'b0}}};
                q_data[wptr] <= al_data;
                q_be[wptr]   <= al_be;
                wptr         <= wptr + PW'(1);
            end
            if (deq)
                rptr <= rptr + PW'(1);
            if (enq && !deq)
                count <= count + CW'(1);
            else if (!enq && deq)
                count <= count - CW'(1);
        end
    end

    // Head entry comes straight out of storage: no enqueue bypass.
    assign O_empty     = (count == '0);
    assign O_mem_valid = !O_empty;
    assign O_mem_addr  = q_addr[rptr];
    assign O_mem_data  = q_data[rptr];
    assign O_mem_be    = q_be[rptr];
    assign O_count     = count;
    assign O_fault     = fault_q;

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
    import store_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // XLEN=32 instance
    logic        v32 = 0, mr32 = 0;
    logic [2:0]  sel32 = 0;
    logic [31:0] a32 = 0, d32 = 0;
    logic        rdy32, flt32, mv32, emp32;
    logic [31:0] ma32, md32;
    logic [3:0]  be32;
    logic [2:0]  cnt32;

    // XLEN=64 instance
    logic        v64 = 0, mr64 = 0;
    logic [2:0]  sel64 = 0;
    logic [31:0] a64 = 0;
    logic [63:0] d64 = 0;
    logic        rdy64, flt64, mv64, emp64;
    logic [31:0] ma64;
    logic [63:0] md64;
    logic [7:0]  be64;
    logic [2:0]  cnt64;

    int checks = 0;
    int errors = 0;

    store_queue #(.XLEN(32), .DEPTH(4), .AWIDTH(32)) dut32 (
        .I_clk(clk), .I_rst_n(rst_n), .I_valid(v32), .O_ready(rdy32),
        .I_storesel(sel32), .I_addr(a32), .I_data(d32), .O_fault(flt32),
        .O_mem_valid(mv32), .I_mem_ready(mr32), .O_mem_addr(ma32),
        .O_mem_data(md32), .O_mem_be(be32), .O_count(cnt32), .O_empty(emp32)
    );

    store_queue #(.XLEN(64), .DEPTH(4), .AWIDTH(32)) dut64 (
        .I_clk(clk), .I_rst_n(rst_n), .I_valid(v64), .O_ready(rdy64),
        .I_storesel(sel64), .I_addr(a64), .I_data(d64), .O_fault(flt64),
        .O_mem_valid(mv64), .I_mem_ready(mr64), .O_mem_addr(ma64),
        .O_mem_data(md64), .O_mem_be(be64), .O_count(cnt64), .O_empty(emp64)
    );

    // Reference model for the 32-bit queue: a queue of expected bus beats.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    bit   exp_fault = 0;

    function automatic bit ref_store(input logic [2:0] sel, input logic [31:0] addr,
                                     input logic [31:0] data, output ent_t e);
        int unsigned sz, off;
        longint unsigned m;
        e = '0;
        case (sel)
            3'b000:  sz = 1;
            3'b001:  sz = 2;
            3'b010:  sz = 4;
            default: sz = 0;   // SD is too wide for 32 bits; others undefined
        endcase
        if (sz == 0) return 1'b1;
        if ((addr % sz) != 0) return 1'b1;
        off  = addr % 4;
        m    = (64'd1 << (8 * sz)) - 64'd1;
        e.a  = addr & ~32'd3;
        e.be = 4'(((1 << sz) - 1) << off);
        e.d  = 32'((64'(data) & m) << (8 * off));
        return 1'b0;
    endfunction

    function automatic logic [31:0] pat(input int k);
        return 32'hA500_0000 ^ (32'(k) * 32'h0101_0101);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mv32 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", mv32); end
        checks++; if (emp32 !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h exp 1", emp32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", rdy32); end
        checks++; if (flt32 !== 1'b0) begin errors++; $display("FAIL reset_fault got %0h exp 0", flt32); end
        checks++; if (cnt32 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt32); end
        checks++; if ({ma32, md32, be32} !== 68'd0) begin errors++; $display("FAIL reset_bus got %h %h %h exp 0", ma32, md32, be32); end
        checks++; if (mv64 !== 1'b0) begin errors++; $display("FAIL reset_valid64 got %0h exp 0", mv64); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sb();
        v32 = 1; sel32 = STORE_SB; a32 = 32'h1003; d32 = 32'h8080_8080; mr32 = 1;
        tick();
        v32 = 0;
        checks++; if (mv32 !== 1'b1) begin errors++; $display("FAIL sb_valid got %0h exp 1", mv32); end
        checks++; if (ma32 !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", ma32); end
        checks++; if (md32 !== 32'h8000_0000) begin errors++; $display("FAIL sb_data got %h exp 80000000", md32); end
        checks++; if (be32 !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", be32); end
        tick();
        checks++; if (emp32 !== 1'b1) begin errors++; $display("FAIL sb_drained got %0h exp 1", emp32); end
        mr32 = 0;
    endtask

    task automatic test_sh_fault();
        v32 = 1; sel32 = STORE_SH; a32 = 32'h2002; d32 = 32'h1234_ABCD;
        tick();
        v32 = 0;
        checks++; if (md32 !== 32'hABCD_0000) begin errors++; $display("FAIL sh_data got %h exp abcd0000", md32); end
        checks++; if (be32 !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", be32); end
        checks++; if (flt32 !== 1'b0) begin errors++; $display("FAIL sh_nofault got %0h exp 0", flt32); end
        v32 = 1; sel32 = STORE_SW; a32 = 32'h2001; d32 = 32'h5555_5555;
        tick();
        v32 = 0;
        checks++; if (flt32 !== 1'b1) begin errors++; $display("FAIL sw_mis_fault got %0h exp 1", flt32); end
        checks++; if (cnt32 !== 3'd1) begin errors++; $display("FAIL sw_mis_count got %0d exp 1", cnt32); end
        tick();
        checks++; if (flt32 !== 1'b0) begin errors++; $display("FAIL fault_pulse got %0h exp 0", flt32); end
        v32 = 1; sel32 = STORE_SD; a32 = 32'h10;
        tick();
        v32 = 0;
        checks++; if (flt32 !== 1'b1) begin errors++; $display("FAIL sd32_fault got %0h exp 1", flt32); end
        checks++; if (cnt32 !== 3'd1) begin errors++; $display("FAIL sd32_count got %0d exp 1", cnt32); end
        mr32 = 1;
        tick();
        checks++; if (emp32 !== 1'b1) begin errors++; $display("FAIL sh_drained got %0h exp 1", emp32); end
        mr32 = 0;
    endtask

    task automatic test_sd64();
        v64 = 1; sel64 = STORE_SD; a64 = 32'h10; d64 = 64'h0123_4567_89AB_CDEF;
        tick();
        sel64 = STORE_SW; a64 = 32'h14; d64 = 64'h0000_0000_DEAD_BEEF;
        tick();
        v64 = 0;
        checks++; if (ma64 !== 32'h10) begin errors++; $display("FAIL sd64_addr got %h exp 00000010", ma64); end
        checks++; if (md64 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL sd64_data got %h exp 0123456789abcdef", md64); end
        checks++; if (be64 !== 8'hFF) begin errors++; $display("FAIL sd64_be got %h exp ff", be64); end
        checks++; if (cnt64 !== 3'd2) begin errors++; $display("FAIL sd64_count got %0d exp 2", cnt64); end
        v64 = 1; sel64 = STORE_SD; a64 = 32'h14;
        tick();
        v64 = 0;
        checks++; if (flt64 !== 1'b1) begin errors++; $display("FAIL sd64_mis_fault got %0h exp 1", flt64); end
        v64 = 1; sel64 = 3'b111; a64 = 32'h20;
        tick();
        v64 = 0;
        checks++; if (flt64 !== 1'b1) begin errors++; $display("FAIL illegal_sel_fault got %0h exp 1", flt64); end
        checks++; if (cnt64 !== 3'd2) begin errors++; $display("FAIL illegal_sel_count got %0d exp 2", cnt64); end
        mr64 = 1;
        tick();
        checks++; if (md64 !== 64'hDEAD_BEEF_0000_0000) begin errors++; $display("FAIL sw64_data got %h exp deadbeef00000000", md64); end
        checks++; if (be64 !== 8'hF0) begin errors++; $display("FAIL sw64_be got %h exp f0", be64); end
        checks++; if (ma64 !== 32'h10) begin errors++; $display("FAIL sw64_addr got %h exp 00000010", ma64); end
        tick();
        checks++; if (emp64 !== 1'b1) begin errors++; $display("FAIL sd64_drained got %0h exp 1", emp64); end
        mr64 = 0;
    endtask

    task automatic test_full_stall();
        mr32 = 0; v32 = 1; sel32 = STORE_SW;
        for (int i = 0; i < 5; i++) begin
            a32 = 32'h100 + 32'(4 * i); d32 = pat(40 + i);
            checks++; if (rdy32 !== (i < 4)) begin errors++; $display("FAIL fill_ready[%0d] got %0h exp %0h", i, rdy32, (i < 4)); end
            tick();
        end
        checks++; if (cnt32 !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", cnt32); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ma32 !== 32'h100 || md32 !== pat(40)) begin errors++; $display("FAIL stall_hold got %h %h exp 00000100 %h", ma32, md32, pat(40)); end
            checks++; if (rdy32 !== 1'b0) begin errors++; $display("FAIL stall_ready got %0h exp 0", rdy32); end
            tick();
        end
        v32 = 0; mr32 = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ma32 !== 32'h100 + 32'(4 * i) || md32 !== pat(40 + i) || be32 !== 4'hF) begin
                errors++; $display("FAIL drain_order[%0d] got %h %h %h exp %h %h f", i, ma32, md32, be32, 32'h100 + 32'(4 * i), pat(40 + i));
            end
            tick();
        end
        checks++; if (emp32 !== 1'b1) begin errors++; $display("FAIL full_drained got %0h exp 1", emp32); end
        mr32 = 0;
    endtask

    task automatic test_back_to_back();
        int h, n, c;
        bit acc;
        mr32 = 0; v32 = 1; sel32 = STORE_SW;
        for (int i = 0; i < 4; i++) begin
            a32 = 32'h300 + 32'(4 * i); d32 = pat(i);
            tick();
        end
        h = 0; n = 4; c = 4;
        a32 = 32'h300 + 32'(4 * n); d32 = pat(n);
        mr32 = 1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (cnt32 !== 3'(c) || rdy32 !== (c != 4)) begin errors++; $display("FAIL b2b_count[%0d] got %0d/%0h exp %0d/%0h", k, cnt32, rdy32, c, (c != 4)); end
            checks++; if (ma32 !== 32'h300 + 32'(4 * h) || md32 !== pat(h)) begin errors++; $display("FAIL b2b_order[%0d] got %h %h exp %h %h", k, ma32, md32, 32'h300 + 32'(4 * h), pat(h)); end
            acc = (c != 4);
            tick();
            h++;
            c = c - 1 + int'(acc);
            if (acc) begin
                n++;
                a32 = 32'h300 + 32'(4 * n); d32 = pat(n);
            end
        end
        v32 = 0;
        while (c > 0) begin
            checks++; if (ma32 !== 32'h300 + 32'(4 * h) || md32 !== pat(h)) begin errors++; $display("FAIL b2b_tail got %h %h exp %h %h", ma32, md32, 32'h300 + 32'(4 * h), pat(h)); end
            tick();
            h++; c--;
        end
        checks++; if (emp32 !== 1'b1) begin errors++; $display("FAIL b2b_drained got %0h exp 1", emp32); end
        mr32 = 0;
    endtask

    task automatic test_random();
        ent_t e;
        bit offer, f;
        mq.delete();
        exp_fault = 0;
        for (int c = 0; c < 406; c++) begin
            if (c < 400) begin
                v32 = ($urandom_range(99) < 70);
                case ($urandom_range(9))
                    0, 1, 2: sel32 = STORE_SB;
                    3, 4:    sel32 = STORE_SH;
                    5, 6, 7: sel32 = STORE_SW;
                    8:       sel32 = STORE_SD;
                    default: sel32 = 3'b110;
                endcase
                a32  = 32'($urandom_range(16'hFFFF));
                d32  = $urandom;
                mr32 = ($urandom_range(99) < 50);
            end else begin
                v32 = 0; mr32 = 1;
            end
            #4;
            checks++; if (cnt32 !== 3'(mq.size()) || rdy32 !== (mq.size() != 4) || mv32 !== (mq.size() != 0)) begin
                errors++; $display("FAIL rnd_state[%0d] got cnt %0d rdy %0h vld %0h exp %0d", c, cnt32, rdy32, mv32, mq.size());
            end
            checks++; if (flt32 !== exp_fault) begin errors++; $display("FAIL rnd_fault[%0d] got %0h exp %0h", c, flt32, exp_fault); end
            if (mq.size() != 0) begin
                checks++; if (ma32 !== mq[0].a || md32 !== mq[0].d || be32 !== mq[0].be) begin
                    errors++; $display("FAIL rnd_head[%0d] got %h %h %h exp %h %h %h", c, ma32, md32, be32, mq[0].a, mq[0].d, mq[0].be);
                end
            end
            offer = v32 && (mq.size() < 4);
            f = offer ? ref_store(sel32, a32, d32, e) : 1'b0;
            if (mq.size() != 0 && mr32) void'(mq.pop_front());
            if (offer && !f) mq.push_back(e);
            exp_fault = offer && f;
            @(posedge clk);
            #1;
        end
        checks++; if (mq.size() != 0 || emp32 !== 1'b1) begin errors++; $display("FAIL rnd_drained got %0h exp 1 (model %0d)", emp32, mq.size()); end
        v32 = 0; mr32 = 0;
    endtask

    task automatic test_async_reset();
        mr32 = 0; v32 = 1; sel32 = STORE_SW;
        for (int i = 0; i < 3; i++) begin
            a32 = 32'h500 + 32'(4 * i); d32 = pat(70 + i);
            tick();
        end
        v32 = 0;
        checks++; if (cnt32 !== 3'd3 || mv32 !== 1'b1) begin errors++; $display("FAIL prereset_state got %0d %0h exp 3 1", cnt32, mv32); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (mv32 !== 1'b0 || emp32 !== 1'b1 || rdy32 !== 1'b1) begin errors++; $display("FAIL async_reset got vld %0h emp %0h rdy %0h exp 0 1 1", mv32, emp32, rdy32); end
        checks++; if (cnt32 !== 3'd0 || {ma32, md32, be32} !== 68'd0) begin errors++; $display("FAIL async_reset_bus got %0d %h %h %h exp 0", cnt32, ma32, md32, be32); end
        @(negedge clk);
        rst_n = 1;
        tick();
        mr32 = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mv32 !== 1'b0 || cnt32 !== 3'd0) begin errors++; $display("FAIL post_reset_stale got %0h %0d exp 0 0", mv32, cnt32); end
            tick();
        end
        mr32 = 0;
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh_fault();
        test_sd64();
        test_full_stall();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
